// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// The divider handles one operation at a time. Divide-by-zero and signed
// overflow finish in one cycle. All other operations iterate once per
// quotient bit, then run a sign-fix cycle.
module seq_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_signed,
  output logic             div_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             out_valid_q, out_valid_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] amag, bmag;
  logic             div_zero, sgn_ovf;
  logic [WIDTH+1:0] diff;

  // Operand magnitudes. The magnitude of the most negative value fits in
  // WIDTH unsigned bits, so no extra width is needed here.
  assign a_neg    = div_signed & dividend[WIDTH-1];
  assign b_neg    = div_signed & divisor[WIDTH-1];
  assign amag     = a_neg ? -dividend : dividend;
  assign bmag     = b_neg ? -divisor  : divisor;
  assign div_zero = (divisor == '0);
  assign sgn_ovf  = div_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (divisor == '1);

  // Trial subtraction on the shifted partial remainder. The shifted value
  // can need WIDTH+1 bits, so the top bit of diff serves as the borrow.
  assign diff = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, bmag_q};

  assign div_ready = (state_q == IDLE) || (state_q == DONE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  // State register. An asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bmag_q      <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      bmag_q      <= bmag_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic: accept, iterate, sign-fix, then hold the result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    bmag_d      = bmag_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (div_valid) begin
          out_valid_d = 1'b0;
          sign_q_d    = a_neg ^ b_neg;
          sign_r_d    = a_neg;
          bmag_d      = bmag;
          rem_d       = '0;
          quo_d       = amag;
          cnt_d       = '0;
          if (div_zero) begin
            quotient_d  = '1;
            remainder_d = dividend;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (sgn_ovf) begin
            quotient_d  = dividend;
            remainder_d = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (!diff[WIDTH+1]) begin
          rem_d = diff[WIDTH-1:0];
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        end
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = sign_q_q ? -quo_q : quo_q;
        remainder_d = sign_r_q ? -rem_q : rem_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: fixed vectors, hand-written corner sequences and
// random operations checked against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         reset;
  logic         div_valid;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         div_signed;
  logic         div_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[7];

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_valid (div_valid),
    .dividend  (dividend),
    .divisor   (divisor),
    .div_signed(div_signed),
    .div_ready (div_ready),
    .out_valid (out_valid),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain language-level division with the RISC-V special cases.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output int lat);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1; r = a; lat = 1;
    end else if (s && a == MINV && b == '1) begin
      q = a; r = '0; lat = 1;
    end else if (s) begin
      q = sa / sb; r = sa % sb; lat = W + 2;
    end else begin
      q = a / b; r = a % b; lat = W + 2;
    end
  endfunction

  // Issue one request and wait for its result. Junk requests are driven
  // while the divider is busy; they must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int elat, input string name);
    int  lat;
    int  guard;
    bit  ready_seen;
    guard = 0;
    while (!div_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    div_valid  = 1'b1;
    dividend   = a;
    divisor    = b;
    div_signed = s;
    @(posedge clk); #1;
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (div_ready) ready_seen = 1'b1;
      div_valid  = 1'($urandom);
      dividend   = {$urandom, $urandom};
      divisor    = {$urandom, $urandom};
      div_signed = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    div_valid = 1'b0;
    chk({name, " latency"}, W'(lat), W'(elat));
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    if (elat > 1) chk({name, " ready while busy"}, W'(ready_seen), W'(0));
  endtask

  initial begin
    logic [W-1:0] a, b, eq, er, hq, hr;
    logic         s;
    int           elat, mode;

    vecs[0] = '{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 66, "u100/7"};
    vecs[1] = '{-64'sd7, 64'd2, 1'b1, -64'sd3, -64'sd1, 66, "s-7/2"};
    vecs[2] = '{64'd7, -64'sd2, 1'b1, -64'sd3, 64'd1, 66, "s7/-2"};
    vecs[3] = '{64'd5, 64'd0, 1'b1, '1, 64'd5, 1, "s5/0"};
    vecs[4] = '{64'd5, 64'd0, 1'b0, '1, 64'd5, 1, "u5/0"};
    vecs[5] = '{MINV, '1, 1'b1, MINV, 64'd0, 1, "s ovf"};
    vecs[6] = '{MINV, '1, 1'b0, 64'd0, MINV, 66, "u min/ones"};

    div_valid  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    div_signed = 1'b0;
    reset      = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset ready", W'(div_ready), W'(1));
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset quotient", quotient, '0);
    chk("reset remainder", remainder, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].lat, vecs[i].name);

    // Back-to-back: second accept lands in the first DONE cycle.
    run_op('1, 64'd3, 1'b0, 64'h5555_5555_5555_5555, 64'd0, 66, "b2b first");
    run_op(64'd10, 64'd3, 1'b0, 64'd3, 64'd1, 66, "b2b second");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold out_valid", W'(out_valid), W'(1));
      chk("hold quotient", quotient, 64'd3);
      chk("hold remainder", remainder, 64'd1);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 9));
      s = 1'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (mode == 0) b = '0;
      else if (mode == 1) b = '1;
      else if (mode == 2) begin a = MINV; b = '1; end
      else if (mode < 6) begin
        b = W'($urandom_range(1, 1000));
        if (s && $urandom_range(0, 1) == 1) b = -b;
      end
      if (mode == 9) a = W'($urandom_range(0, 50));
      ref_div(a, b, s, eq, er, elat);
      run_op(a, b, s, eq, er, elat, "random");
    end

    // Asynchronous reset while iterating (cnt=30).
    hq = quotient;
    hr = remainder;
    chk("pre-abort result present", W'(out_valid), W'(1));
    div_valid  = 1'b1;
    dividend   = 64'd1000;
    divisor    = 64'd3;
    div_signed = 1'b0;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort ready", W'(div_ready), W'(1));
    chk("abort out_valid", W'(out_valid), W'(0));
    chk("abort quotient", quotient, '0);
    chk("abort remainder", remainder, '0);
    if (hq == '0 && hr == '0) chk("abort prior result nonzero", hq | hr, '1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    run_op(64'd9, 64'd4, 1'b0, 64'd2, 64'd1, 66, "after reset 9/4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
